vga_top: RTL and testbench

//  Self-contained VGA test-pattern source, the top-level block driven by a single
//  24 MHz board clock. Generates 640x480 VGA timing (~57 Hz frame) and drives eight

---
 rtl/vga_top_if.sv | 20 ++
 rtl/vga_top.sv | 135 +++++++++++++
 tb/tb_vga_top.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_top_if.sv
// -----------------------------------------------------------------------------
// vga_top_if : video output bundle of the VGA test-pattern source.
//
// Signals
//   rgb    [5:0]  pixel colour {R[1:0],G[1:0],B[1:0]}
//   hsync         horizontal sync
//   vsync         vertical sync
//
// Modports
//   master  : the pattern generator, which drives all three signals
//   slave   : a video consumer (DAC, bench), which reads them
// -----------------------------------------------------------------------------
interface vga_top_if;
  logic [5:0] rgb;
  logic       hsync;
  logic       vsync;

  modport master (output rgb, output hsync, output vsync);
  modport slave  (input  rgb, input  hsync, input  vsync);
endinterface

// File: rtl/vga_top.sv
// -----------------------------------------------------------------------------
// vga_top : self-contained VGA test-pattern source (640x480 timing from a
// 24 MHz pixel clock). It draws eight vertical colour bars and generates the
// horizontal and vertical sync pulses.
//
// Ports
//   clk   in   pixel clock, rising edge
//   rst   in   asynchronous reset, active-high
//   vga   out  vga_top_if.master : rgb[5:0], hsync, vsync
//
// Optional build macro
//   VGA_BORDER_EN : when defined, active pixels on the first/last column and
//                   the first/last line are forced to white (6'h3F). Sync
//                   timing is the same with or without it.
//
// Outputs are registered. The pixel at counter position (h,v) appears on the
// clock edge that advances the counters past it, so rgb, hsync and vsync stay
// mutually aligned with a single cycle of latency.
// -----------------------------------------------------------------------------
module vga_top #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic     clk,
  input  logic     rst,
  vga_top_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

  // Each colour bit of the bar index is replicated across a 2-bit channel.
  function automatic logic [5:0] bar_colour(input logic [2:0] idx);
    return {{2{idx[2]}}, {2{idx[1]}}, {2{idx[0]}}};
  endfunction

  logic [HW-1:0] h_cnt_p0;
  logic [VW-1:0] v_cnt_p0;
  logic [BW-1:0] bar_px_p0;
  logic [2:0]    bar_idx_p0;

  logic [5:0]    rgb_p1;
  logic          hsync_p1;
  logic          vsync_p1;

  logic          line_end;
  logic          active;
  logic          hs_on;
  logic          vs_on;
  logic [5:0]    pix_rgb;

  assign line_end = (h_cnt_p0 == H_LAST);
  assign active   = (h_cnt_p0 < H_ACT) && (v_cnt_p0 < V_ACT);
  assign hs_on    = (h_cnt_p0 >= HS_START) && (h_cnt_p0 < HS_END);
  assign vs_on    = (v_cnt_p0 >= VS_START) && (v_cnt_p0 < VS_END);

  always_comb begin
    pix_rgb = 6'h00;
    if (active) begin
      pix_rgb = bar_colour(bar_idx_p0);
`ifdef VGA_BORDER_EN
      if ((h_cnt_p0 == '0) || (h_cnt_p0 == H_ACT - HW'(1)) ||
          (v_cnt_p0 == '0) || (v_cnt_p0 == V_ACT - VW'(1)))
        pix_rgb = 6'h3F;
`endif
    end
  end

  // Stage p0: raster position plus bar sub-counter. The bar index steps every
  // BAR_W pixels instead of dividing h; it runs on into the blanking interval
  // harmlessly and is cleared at every line wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_p0   <= '0;
      v_cnt_p0   <= '0;
      bar_px_p0  <= '0;
      bar_idx_p0 <= '0;
    end else begin
      if (line_end) begin
        h_cnt_p0   <= '0;
        bar_px_p0  <= '0;
        bar_idx_p0 <= '0;
        v_cnt_p0   <= (v_cnt_p0 == V_LAST) ? '0 : v_cnt_p0 + VW'(1);
      end else begin
        h_cnt_p0 <= h_cnt_p0 + HW'(1);
        if (bar_px_p0 == BAR_LAST) begin
          bar_px_p0  <= '0;
          bar_idx_p0 <= bar_idx_p0 + 3'd1;
        end else begin
          bar_px_p0 <= bar_px_p0 + BW'(1);
        end
      end
    end
  end

  // Stage p1: registered video outputs. They are held at blank/inactive under
  // reset because they leave the chip directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_p1   <= 6'h00;
      hsync_p1 <= ~SYNC_POL;
      vsync_p1 <= ~SYNC_POL;
    end else begin
      rgb_p1   <= pix_rgb;
      hsync_p1 <= hs_on ? SYNC_POL : ~SYNC_POL;
      vsync_p1 <= vs_on ? SYNC_POL : ~SYNC_POL;
    end
  end

  assign vga.rgb   = rgb_p1;
  assign vga.hsync = hsync_p1;
  assign vga.vsync = vsync_p1;

endmodule

// File: tb/tb_vga_top.sv
// -----------------------------------------------------------------------------
// tb_vga_top : bench for vga_top. Horizontal timing uses the full 640-pixel
// line; the vertical timing uses a shortened frame (8 visible lines) so whole
// frames fit in a short run. The reference model maps a pixel number counted
// from reset release to the expected {rgb,hsync,vsync} with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_vga_top;

  localparam int HA = 640, HF = 16, HS = 96, HB = 48;
  localparam int VA = 8,   VF = 2,  VS = 2,  VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;

`ifdef VGA_BORDER_EN
  localparam logic [5:0] BRD = 6'h3F;
`else
  localparam logic [5:0] BRD = 6'h00;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vga_top_if vif();

  vga_top #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vga(vif)
  );

  int errors = 0;
  int checks = 0;
  int pix_next = 0;
  int pix = -1;

  typedef struct {
    int         h;
    int         v;
    logic [5:0] rgb;
  } vec_t;

  vec_t tbl[11];

  // Expected {rgb, hsync, vsync} for the n-th pixel after reset release.
  function automatic logic [7:0] model(input int n);
    int h, v, i;
    logic [5:0] c;
    logic hs, vs;
    h  = n % HT;
    v  = (n / HT) % VT;
    hs = !((h >= HA + HF) && (h < HA + HF + HS));
    vs = !((v >= VA + VF) && (v < VA + VF + VS));
    c  = 6'h00;
    if (h < HA && v < VA) begin
      i = h / (HA / 8);
      c = {i[2], i[2], i[1], i[1], i[0], i[0]};
`ifdef VGA_BORDER_EN
      if (h == 0 || h == HA - 1 || v == 0 || v == VA - 1) c = 6'h3F;
`endif
    end
    return {c, hs, vs};
  endfunction

  function automatic logic [7:0] observed();
    return {vif.rgb, vif.hsync, vif.vsync};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (pixel %0d)", name, act, exp, pix);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    pix = pix_next;
    pix_next++;
  endtask

  // Runs forward to pixel target, spot-checking against the model at random.
  task automatic advance_to(input int target, input int rate);
    while (pix < target) begin
      tick();
      if ($urandom_range(0, rate - 1) == 0)
        check("pixel_model", observed(), model(pix));
    end
  endtask

  task automatic pulse_reset(input int len);
    #2 rst = 1'b1;
    #1 check("async_reset", observed(), {6'h00, 1'b1, 1'b1});
    repeat (len) begin
      @(posedge clk);
      #1 check("reset_hold", observed(), {6'h00, 1'b1, 1'b1});
    end
    @(negedge clk);
    rst = 1'b0;
    pix_next = 0;
    pix = -1;
  endtask

  initial begin
    int fall;
    logic hs_prev, vs_prev;
    int hs_last, vs_last, hs_falls, vs_falls, stop;

    tbl[0]  = '{5,      0,      BRD};
    tbl[1]  = '{0,      1,      BRD};
    tbl[2]  = '{80,     1,      6'h03};
    tbl[3]  = '{320,    1,      6'h30};
    tbl[4]  = '{639,    1,      6'h3F};
    tbl[5]  = '{640,    1,      6'h00};
    tbl[6]  = '{799,    1,      6'h00};
    tbl[7]  = '{160,    2,      6'h0C};
    tbl[8]  = '{5,      VA - 1, BRD};
    tbl[9]  = '{100,    VA,     6'h00};
    tbl[10] = '{400,    VT - 1, 6'h00};

    // Reset held for 5 clocks: blank and sync inactive throughout.
    #1 rst = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1 check("reset_state", observed(), {6'h00, 1'b1, 1'b1});
    end
    @(negedge clk);
    rst = 1'b0;
    pix_next = 0;
    pix = -1;

    tick();
    check("first_pixel", observed(), model(0));

    // Colour table.
    for (int k = 0; k < 11; k++) begin
      advance_to(tbl[k].v * HT + tbl[k].h, 4);
      check($sformatf("colour_h%0d_v%0d", tbl[k].h, tbl[k].v), vif.rgb, tbl[k].rgb);
    end

    // Mid-frame reset at line 4, pixel 300 (bar 3 showing).
    advance_to(FR + 4 * HT + 300, 4);
    check("pre_reset_bar3", vif.rgb, 6'h0F);
    pulse_reset(3);

    fall = -1;
    hs_prev = vif.hsync;
    for (int k = 0; k < 2000 && fall < 0; k++) begin
      tick();
      if (hs_prev && !vif.hsync) fall = pix;
      hs_prev = vif.hsync;
    end
    check("hsync_fall_after_reset", fall, HA + HF);

    // Sync timing measurement across more than two frames.
    hs_prev = vif.hsync;
    vs_prev = vif.vsync;
    hs_last = fall;
    vs_last = -1;
    hs_falls = 0;
    vs_falls = 0;
    stop = 2 * FR + (VA + VF + VS) * HT + 10;
    for (int k = 0; k < 40000 && pix < stop; k++) begin
      tick();
      if ($urandom_range(0, 7) == 0)
        check("pixel_model", observed(), model(pix));
      if (hs_prev && !vif.hsync) begin
        hs_falls++;
        check("hsync_phase", pix % HT, HA + HF);
        if (hs_last >= 0) check("hsync_period", pix - hs_last, HT);
        hs_last = pix;
      end
      if (!hs_prev && vif.hsync && hs_last >= 0)
        check("hsync_width", pix - hs_last, HS);
      if (vs_prev && !vif.vsync) begin
        vs_falls++;
        check("vsync_phase", pix % FR, (VA + VF) * HT);
        if (vs_last >= 0) check("vsync_period", pix - vs_last, FR);
        vs_last = pix;
      end
      if (!vs_prev && vif.vsync && vs_last >= 0)
        check("vsync_width", pix - vs_last, VS * HT);
      hs_prev = vif.hsync;
      vs_prev = vif.vsync;
    end
    check("hsync_edge_count", hs_falls, 41);
    check("vsync_edge_count", vs_falls, 3);

    // Randomly placed resets of random length, then resume model checks.
    repeat (2) begin
      advance_to(pix + $urandom_range(100, 3000), 2);
      pulse_reset($urandom_range(1, 4));
      advance_to(2 * HT + $urandom_range(0, HT - 1), 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
